// File: rtl/pong_score_keeper.sv
// -----------------------------------------------------------------------------
// pong_score_keeper
//
// Game-state controller for Pong. Once per frame tick it decides whether the
// ball has crossed a goal line, keeps both players' scores, declares a winner
// and gates serves from the two push-buttons.
//
// Optional feature macro: SCORE_HEX_EN
//   When defined, adds hex_p1/hex_p2: registered, active-low 7-segment images
//   of the scores (segment order gfedcba), one cycle behind the score.
//
// Ports:
//   CLOCK_50     in   sole clock
//   reset_n      in   asynchronous active-low reset
//   frame_tick   in   one-cycle pulse per game update
//   ball_x       in   ball left edge (pixels)
//   ball_w       in   ball width (pixels)
//   serve_p1_n   in   raw active-low serve button, player 1 (left)
//   serve_p2_n   in   raw active-low serve button, player 2 (right)
//   ball_hold    out  1 = ball held at centre with zero velocity
//   serve_pulse  out  one-cycle launch strobe
//   serve_dir    out  0 = launch toward +x, 1 = toward -x
//   score_p1/p2  out  player scores
//   winner       out  00 none, 01 P1, 10 P2
//   hex_p1/p2    out  (SCORE_HEX_EN only) 7-segment score images
// -----------------------------------------------------------------------------
module pong_score_keeper #(
   parameter int WIN_SCORE     = 7,
   parameter int LEFT_GOAL     = 10,
   parameter int RIGHT_GOAL    = 630,
   parameter int SERVE_LOCKOUT = 30,
   parameter int POINT_HOLD    = 60
) (
   input  logic       CLOCK_50,
   input  logic       reset_n,
   input  logic       frame_tick,
   input  logic [9:0] ball_x,
   input  logic [9:0] ball_w,
   input  logic       serve_p1_n,
   input  logic       serve_p2_n,
   output logic       ball_hold,
   output logic       serve_pulse,
   output logic       serve_dir,
   output logic [3:0] score_p1,
   output logic [3:0] score_p2,
   output logic [1:0] winner
`ifdef SCORE_HEX_EN
   ,
   output logic [6:0] hex_p1,
   output logic [6:0] hex_p2
`endif
);

   localparam logic [3:0]  WIN_L   = 4'(WIN_SCORE);
   localparam logic [9:0]  LEFT_L  = 10'(LEFT_GOAL);
   localparam logic [10:0] RIGHT_L = 11'(RIGHT_GOAL);
   localparam logic [7:0]  LOCK_L  = 8'(SERVE_LOCKOUT);
   localparam logic [7:0]  HOLD_L  = 8'(POINT_HOLD);

   typedef enum logic [1:0] {ST_HOLD, ST_PLAY, ST_POINT, ST_OVER} state_t;

   // Button synchronizer, bit 0 = P1, bit 1 = P2 (active-low levels)
   logic [1:0] btn_meta_q, btn_sync_q;

   state_t     state_q, state_d;
   logic [7:0] fcnt_q, fcnt_d;
   logic       ball_hold_q, ball_hold_d;
   logic       serve_pulse_q, serve_pulse_d;
   logic       serve_dir_q, serve_dir_d;
   logic [3:0] score_p1_q, score_p1_d;
   logic [3:0] score_p2_q, score_p2_d;
   logic [1:0] winner_q, winner_d;

   logic        p1_pressed, p2_pressed;
   logic [10:0] ball_right;

   assign p1_pressed = ~btn_sync_q[0];
   assign p2_pressed = ~btn_sync_q[1];
   // Widened so a ball near the right edge cannot wrap past the goal line
   assign ball_right = {1'b0, ball_x} + {1'b0, ball_w};

`ifdef SCORE_HEX_EN
   logic [6:0] hex_p1_q, hex_p1_d;
   logic [6:0] hex_p2_q, hex_p2_d;

   function automatic logic [6:0] seg7(input logic [3:0] v);
      case (v)
         4'h0: seg7 = 7'b1000000;
         4'h1: seg7 = 7'b1111001;
         4'h2: seg7 = 7'b0100100;
         4'h3: seg7 = 7'b0110000;
         4'h4: seg7 = 7'b0011001;
         4'h5: seg7 = 7'b0010010;
         4'h6: seg7 = 7'b0000010;
         4'h7: seg7 = 7'b1111000;
         4'h8: seg7 = 7'b0000000;
         4'h9: seg7 = 7'b0010000;
         4'hA: seg7 = 7'b0001000;
         4'hB: seg7 = 7'b0000011;
         4'hC: seg7 = 7'b1000110;
         4'hD: seg7 = 7'b0100001;
         4'hE: seg7 = 7'b0000110;
         default: seg7 = 7'b0001110;
      endcase
   endfunction

   // Image follows the registered score, hence one cycle behind it
   always_comb begin
      hex_p1_d = seg7(score_p1_q);
      hex_p2_d = seg7(score_p2_q);
   end

   assign hex_p1 = hex_p1_q;
   assign hex_p2 = hex_p2_q;
`endif

   always_comb begin
      state_d       = state_q;
      fcnt_d        = fcnt_q;
      serve_pulse_d = 1'b0;
      serve_dir_d   = serve_dir_q;
      score_p1_d    = score_p1_q;
      score_p2_d    = score_p2_q;
      winner_d      = winner_q;

      if (frame_tick) begin
         if (fcnt_q != 8'hFF) fcnt_d = fcnt_q + 8'd1;

         case (state_q)
            ST_HOLD: begin
               if (fcnt_q >= LOCK_L) begin
                  // P1 checked first so it wins a simultaneous press
                  if (p1_pressed) begin
                     serve_dir_d   = 1'b0;
                     serve_pulse_d = 1'b1;
                     state_d       = ST_PLAY;
                  end else if (p2_pressed) begin
                     serve_dir_d   = 1'b1;
                     serve_pulse_d = 1'b1;
                     state_d       = ST_PLAY;
                  end
               end
            end
            ST_PLAY: begin
               if (ball_x < LEFT_L) begin
                  if (score_p2_q < WIN_L) score_p2_d = score_p2_q + 4'd1;
                  if (score_p2_d == WIN_L) begin
                     winner_d = 2'b10;
                     state_d  = ST_OVER;
                  end else begin
                     state_d  = ST_POINT;
                  end
               end else if (ball_right > RIGHT_L) begin
                  if (score_p1_q < WIN_L) score_p1_d = score_p1_q + 4'd1;
                  if (score_p1_d == WIN_L) begin
                     winner_d = 2'b01;
                     state_d  = ST_OVER;
                  end else begin
                     state_d  = ST_POINT;
                  end
               end
            end
            ST_POINT: begin
               if (fcnt_q >= HOLD_L) state_d = ST_HOLD;
            end
            ST_OVER: begin
               // New game: scores cleared, ball stays held, no serve
               if ((fcnt_q >= HOLD_L) && (p1_pressed || p2_pressed)) begin
                  score_p1_d = 4'd0;
                  score_p2_d = 4'd0;
                  winner_d   = 2'b00;
                  state_d    = ST_HOLD;
               end
            end
            default: state_d = ST_HOLD;
         endcase

         // Every transition is to a different state, so this marks entry
         if (state_d != state_q) fcnt_d = 8'd0;
      end

      ball_hold_d = (state_d != ST_PLAY);
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         btn_meta_q    <= 2'b11;
         btn_sync_q    <= 2'b11;
         state_q       <= ST_HOLD;
         fcnt_q        <= 8'd0;
         ball_hold_q   <= 1'b1;
         serve_pulse_q <= 1'b0;
         serve_dir_q   <= 1'b0;
         score_p1_q    <= 4'd0;
         score_p2_q    <= 4'd0;
         winner_q      <= 2'b00;
`ifdef SCORE_HEX_EN
         hex_p1_q      <= 7'b1000000;
         hex_p2_q      <= 7'b1000000;
`endif
      end else begin
         btn_meta_q    <= {serve_p2_n, serve_p1_n};
         btn_sync_q    <= btn_meta_q;
         state_q       <= state_d;
         fcnt_q        <= fcnt_d;
         ball_hold_q   <= ball_hold_d;
         serve_pulse_q <= serve_pulse_d;
         serve_dir_q   <= serve_dir_d;
         score_p1_q    <= score_p1_d;
         score_p2_q    <= score_p2_d;
         winner_q      <= winner_d;
`ifdef SCORE_HEX_EN
         hex_p1_q      <= hex_p1_d;
         hex_p2_q      <= hex_p2_d;
`endif
      end
   end

   assign ball_hold   = ball_hold_q;
   assign serve_pulse = serve_pulse_q;
   assign serve_dir   = serve_dir_q;
   assign score_p1    = score_p1_q;
   assign score_p2    = score_p2_q;
   assign winner      = winner_q;

endmodule

// File: tb/tb_pong_score_keeper.sv
// -----------------------------------------------------------------------------
// tb_pong_score_keeper
//
// Self-checking bench for pong_score_keeper: a vector table from reset,
// hand-written win / game-restart and asynchronous-reset sequences, then
// randomized play checked every cycle against a rule-level game model.
// Outputs are sampled 1 ns after the rising edge; inputs change on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_pong_score_keeper;

   localparam int WIN  = 7;
   localparam int LG   = 10;
   localparam int RG   = 630;
   localparam int LOCK = 30;
   localparam int PH   = 60;

   logic       CLOCK_50 = 1'b0;
   logic       reset_n;
   logic       frame_tick;
   logic [9:0] ball_x, ball_w;
   logic       serve_p1_n, serve_p2_n;
   logic       ball_hold, serve_pulse, serve_dir;
   logic [3:0] score_p1, score_p2;
   logic [1:0] winner;
`ifdef SCORE_HEX_EN
   logic [6:0] hex_p1, hex_p2;
`endif

   pong_score_keeper #(
      .WIN_SCORE(WIN), .LEFT_GOAL(LG), .RIGHT_GOAL(RG),
      .SERVE_LOCKOUT(LOCK), .POINT_HOLD(PH)
   ) dut (
      .CLOCK_50(CLOCK_50), .reset_n(reset_n), .frame_tick(frame_tick),
      .ball_x(ball_x), .ball_w(ball_w),
      .serve_p1_n(serve_p1_n), .serve_p2_n(serve_p2_n),
      .ball_hold(ball_hold), .serve_pulse(serve_pulse), .serve_dir(serve_dir),
      .score_p1(score_p1), .score_p2(score_p2), .winner(winner)
`ifdef SCORE_HEX_EN
      , .hex_p1(hex_p1), .hex_p2(hex_p2)
`endif
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Current bench-side stimulus levels (pressed = 1)
   bit cur_p1, cur_p2;
   int cur_bx, cur_bw;

   // ---------------- behavioural game model ----------------
   localparam int M_HOLD = 0, M_PLAY = 1, M_POINT = 2, M_OVER = 3;
   bit model_on = 0;
   int m_state, m_frames, m_s1, m_s2, m_win;
   bit m_pulse, m_dir;

   function automatic void model_reset();
      m_state = M_HOLD; m_frames = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
      m_pulse = 0; m_dir = 0;
   endfunction

   function automatic void model_enter(input int st);
      m_state  = st;
      m_frames = 0;
   endfunction

   function automatic void model_step(input bit tick);
      m_pulse = 0;
      if (!tick) return;
      case (m_state)
         M_HOLD:
            if (m_frames >= LOCK && (cur_p1 || cur_p2)) begin
               m_dir   = cur_p1 ? 1'b0 : 1'b1;
               m_pulse = 1;
               model_enter(M_PLAY);
               return;
            end
         M_PLAY:
            if (cur_bx < LG) begin
               m_s2++;
               if (m_s2 == WIN) begin m_win = 2; model_enter(M_OVER); end
               else model_enter(M_POINT);
               return;
            end else if (cur_bx + cur_bw > RG) begin
               m_s1++;
               if (m_s1 == WIN) begin m_win = 1; model_enter(M_OVER); end
               else model_enter(M_POINT);
               return;
            end
         M_POINT:
            if (m_frames >= PH) begin
               model_enter(M_HOLD);
               return;
            end
         default:
            if (m_frames >= PH && (cur_p1 || cur_p2)) begin
               m_s1 = 0; m_s2 = 0; m_win = 0;
               model_enter(M_HOLD);
               return;
            end
      endcase
      if (m_frames < 255) m_frames++;
   endfunction

   function automatic logic [12:0] model_vec();
      return {m_state != M_PLAY, m_pulse, m_dir, 4'(m_s1), 4'(m_s2), 2'(m_win)};
   endfunction

   function automatic logic [12:0] dut_vec();
      return {ball_hold, serve_pulse, serve_dir, score_p1, score_p2, winner};
   endfunction

   // ---------------- stimulus helpers (entered/left at negedge) ----------------
   task automatic set_inputs(input bit p1, input bit p2, input int bx, input int bw);
      cur_p1 = p1; cur_p2 = p2; cur_bx = bx; cur_bw = bw;
      serve_p1_n = ~p1;
      serve_p2_n = ~p2;
      ball_x = 10'(bx);
      ball_w = 10'(bw);
   endtask

   task automatic step(input bit tick);
      frame_tick = tick;
      @(posedge CLOCK_50);
      #1;
      frame_tick = 1'b0;
      if (model_on) begin
         model_step(tick);
         check("rand_outputs", 32'(dut_vec()), 32'(model_vec()));
      end
      @(negedge CLOCK_50);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0);
   endtask

   task automatic ticks(input int n);
      repeat (n) step(1'b1);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      idle(2);
      reset_n = 1'b1;
      idle(1);
   endtask

   // Serve from fresh HOLD; buttons need 3 idle cycles to clear the synchronizer
   task automatic serve(input bit by_p2);
      set_inputs(!by_p2, by_p2, 320, 8);
      idle(3);
      ticks(LOCK + 1);
      check("serve_pulse", 32'(serve_pulse), 32'(1));
      check("serve_dir", 32'(serve_dir), 32'(by_p2));
   endtask

   task automatic goal(input bit left);
      set_inputs(0, 0, left ? 9 : 700, 8);
      idle(3);
      ticks(1);
   endtask

   task automatic point_wait();
      set_inputs(0, 0, 320, 8);
      ticks(PH + 1);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit p1, p2;
      int bx, bw, nticks;
      bit hold, pulse, dir;
      int s1, s2, win;
   } vec_t;

   vec_t tbl[12];

   initial begin
      logic [12:0] e;

      tbl[0]  = '{1, 0, 320, 8,   30, 1, 0, 0, 0, 0, 0};  // lockout not yet over
      tbl[1]  = '{1, 0, 320, 8,    1, 0, 1, 0, 0, 0, 0};  // 31st tick serves
      tbl[2]  = '{0, 0, 320, 8,    5, 0, 0, 0, 0, 0, 0};  // mid-field play
      tbl[3]  = '{0, 0, 625, 8,    1, 1, 0, 0, 1, 0, 0};  // right goal
      tbl[4]  = '{0, 0, 320, 8,   61, 1, 0, 0, 1, 0, 0};  // POINT -> HOLD
      tbl[5]  = '{0, 1, 320, 8,   30, 1, 0, 0, 1, 0, 0};  // lockout again
      tbl[6]  = '{0, 1, 320, 8,    1, 0, 1, 1, 1, 0, 0};  // P2 serve
      tbl[7]  = '{0, 0,   9, 8,    1, 1, 0, 1, 1, 1, 0};  // left goal
      tbl[8]  = '{0, 0, 320, 8,   61, 1, 0, 1, 1, 1, 0};
      tbl[9]  = '{1, 1, 320, 8,   31, 0, 1, 0, 1, 1, 0};  // both pressed: P1
      tbl[10] = '{0, 0,  10, 620,  3, 0, 0, 0, 1, 1, 0};  // both goal edges exact
      tbl[11] = '{0, 0,  10, 621,  1, 1, 0, 0, 2, 1, 0};  // one past right edge

      reset_n    = 1'b0;
      frame_tick = 1'b0;
      set_inputs(0, 0, 320, 8);
      @(negedge CLOCK_50);
      idle(2);
      check("reset_outputs", 32'(dut_vec()), 32'(13'b1_0_0_0000_0000_00));
`ifdef SCORE_HEX_EN
      check("reset_hex", 32'({hex_p1, hex_p2}), 32'({7'b1000000, 7'b1000000}));
`endif
      reset_n = 1'b1;
      idle(1);

      for (int i = 0; i < 12; i++) begin
         set_inputs(tbl[i].p1, tbl[i].p2, tbl[i].bx, tbl[i].bw);
         idle(3);
         ticks(tbl[i].nticks);
         e = {tbl[i].hold, tbl[i].pulse, tbl[i].dir,
              4'(tbl[i].s1), 4'(tbl[i].s2), 2'(tbl[i].win)};
         check($sformatf("vec%0d", i), 32'(dut_vec()), 32'(e));
      end

      // ---- P2 wins a game, scores freeze, restart after hold time ----
      do_reset();
      repeat (6) begin serve(0); goal(1); point_wait(); end
      check("p2_six", 32'(dut_vec()), 32'({1'b1, 1'b0, 1'b0, 4'd0, 4'd6, 2'b00}));
      serve(1);
      goal(1);
      check("p2_wins", 32'(dut_vec()), 32'({1'b1, 1'b0, 1'b1, 4'd0, 4'd7, 2'b10}));
      idle(1);
`ifdef SCORE_HEX_EN
      check("hex_p2_seven", 32'(hex_p2), 32'(7'b1111000));
`endif
      set_inputs(0, 0, 9, 8);   ticks(4);
      set_inputs(0, 0, 700, 8); ticks(4);
      check("over_frozen", 32'(dut_vec()), 32'({1'b1, 1'b0, 1'b1, 4'd0, 4'd7, 2'b10}));
      set_inputs(0, 0, 320, 8); ticks(PH - 9);
      set_inputs(1, 0, 320, 8); idle(3);
      ticks(1);   // evaluated with 59 frames: still too early
      check("over_early_press", 32'(dut_vec()), 32'({1'b1, 1'b0, 1'b1, 4'd0, 4'd7, 2'b10}));
      ticks(1);
      check("over_restart", 32'(dut_vec()), 32'({1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 2'b00}));
      ticks(LOCK);
      check("restart_lockout", 32'({ball_hold, serve_pulse}), 32'(2'b10));
      ticks(1);
      check("restart_serve", 32'({ball_hold, serve_pulse, serve_dir}), 32'(3'b010));

      // ---- asynchronous reset mid-play with scores 3/4 ----
      do_reset();
      repeat (3) begin serve(0); goal(0); point_wait(); end
      repeat (4) begin serve(1); goal(1); point_wait(); end
      check("scores_3_4", 32'({score_p1, score_p2}), 32'({4'd3, 4'd4}));
      serve(1);
      check("mid_play", 32'(ball_hold), 32'(0));
      #2 reset_n = 1'b0;
      #1;
      check("async_reset", 32'(dut_vec()), 32'(13'b1_0_0_0000_0000_00));
`ifdef SCORE_HEX_EN
      check("async_reset_hex", 32'({hex_p1, hex_p2}), 32'({7'b1000000, 7'b1000000}));
`endif
      @(negedge CLOCK_50);
      reset_n = 1'b1;
      idle(1);

      // ---- randomized play against the model ----
      set_inputs(0, 0, 320, 8);
      idle(3);
      model_reset();
      model_on = 1;
      for (int it = 0; it < 1500; it++) begin
         int r, bx, bw;
         bit p1, p2;
         p1 = ($urandom_range(0, 2) == 0);
         p2 = ($urandom_range(0, 2) == 0);
         r  = int'($urandom_range(0, 9));
         if (r < 2) begin
            bx = int'($urandom_range(0, 9));        bw = int'($urandom_range(0, 20));
         end else if (r < 4) begin
            bx = int'($urandom_range(600, 1023));   bw = int'($urandom_range(0, 40));
         end else if (r == 9) begin
            bx = int'($urandom_range(0, 1023));     bw = int'($urandom_range(0, 1023));
         end else begin
            bx = int'($urandom_range(10, 600));     bw = int'($urandom_range(0, 20));
         end
         set_inputs(p1, p2, bx, bw);
         idle(3);
         ticks(int'($urandom_range(1, 4)));
      end
      model_on = 0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
